ytydla_dma_copy_master: RTL
===========================

Name: ytydla_dma_copy_master

Overview:
AXI4 master copy engine that drives the ytydla memory slave. On a start command it moves word_cnt data words from src_addr to dst_addr. Each word is one single-beat read followed by one single-beat write, with one transaction outstanding. It sits between the ytydla control/CSR logic and the memory-side AXI port, and is the upstream stage that feeds the memory slave's AR/AW/W channels and consumes its R/B channels.

Parameters:
W_ID, 4, AXI ID width; all issued IDs equal ID_VAL.
ID_VAL, 0, constant ID driven on arid/awid and expected back on rid/bid.
W_ADR, 32, AXI address width.
W_DATA, 32, AXI data width in bits (power of 2, >=8).
W_CNT, 16, width of the word-count field.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  command strobe; sampled only in IDLE.
src_addr  in  W_ADR  source byte address.
dst_addr  in  W_ADR  destination byte address.
word_cnt  in  W_CNT  number of W_DATA words to copy.
busy  out  1  high from the cycle after start is accepted until the cycle done is high.
done  out  1  one-cycle completion pulse.
err  out  1  sticky error flag; cleared on the next accepted start.
arid/awid  out  W_ID  = ID_VAL.
araddr/awaddr  out  W_ADR  transfer address.
arlen/awlen  out  8  always 0.
arsize/awsize  out  3  always log2(W_DATA/8).
arvalid/awvalid/wvalid  out  1  channel valids.
arready/awready/wready  in  1  channel readies.
wdata  out  W_DATA  captured read data.
wstrb  out  W_DATA/8  all ones.
wlast  out  1  always 1 when wvalid is high.
rid/bid  in  W_ID  response IDs.
rdata  in  W_DATA  read data.
rresp/bresp  in  2  responses; 0 = OKAY.
rlast  in  1  read last.
rvalid/bvalid  in  1  response valids.
rready/bready  out  1  response readies.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE. All valids, rready, bready, busy, done and err = 0. Addresses, wdata and the word index = 0. Reset mid-transfer aborts immediately; dropping valids at reset is the only allowed valid withdrawal.
- FSM states: IDLE, AR, R, W, B, DONE.
- IDLE: start=1 latches src/dst/word_cnt, clears err, sets idx=0, sets busy.
  - word_cnt=0 -> DONE.
  - src_addr or dst_addr not aligned to W_DATA/8 -> err=1, then DONE.
  - Otherwise -> AR.
  - start outside IDLE is ignored.
- AR: arvalid=1, araddr=src+idx*(W_DATA/8), modulo 2^W_ADR (wraps silently). Hold until arready; then -> R.
- R: rready=1. On rvalid, capture rdata into wdata.
  - rresp!=0, rid!=ID_VAL or rlast=0 -> err=1, then DONE (abort, no write).
  - Otherwise -> W.
- W: awvalid=1 and wvalid=1, asserted in the same cycle; awaddr=dst+idx*(W_DATA/8) with wrap. Each valid drops independently after its own ready handshake; AW and W may complete in either order or in the same cycle. When both are accepted -> B.
- B: bready=1. On bvalid:
  - bresp!=0 or bid!=ID_VAL -> err=1, then DONE.
  - Otherwise idx++; idx==word_cnt -> DONE, else -> AR.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then -> IDLE. err stays until the next accepted start.
- Valid/data outputs are stable while valid is high and ready is low (AXI rule).
- Latency with an always-ready, one-cycle-response slave: 4 cycles per word. done rises the cycle after the final B handshake. Total = 4*N+1 cycles from the start edge to done.
- At most one AR or one AW/W outstanding at any time. A response arriving in an unexpected state is not accepted (ready stays low).

Test Plan:
- Copy 4 words: memory at 0x100 preloaded with 0x11111111, 0x22222222, 0x33333333, 0x44444444; src=0x100, dst=0x200 -> 0x200..0x20C hold the same values; 4 ARs and 4 AWs observed with len=0, size=2; done after 17 cycles; err=0.
- word_cnt=0 -> done pulses on the 2nd cycle after start; no arvalid/awvalid ever seen; err=0.
- Backpressure: random arready/awready/wready/rvalid/bvalid stalls of 0-5 cycles, AW accepted before W and vice versa -> data still correct; valids never drop before their ready.
- Error: slave returns bresp=2 on word 2 of 3 -> err=1, done pulses, word 3 is never read; next start with a clean slave clears err.
- Misaligned src=0x102 -> err=1 and done with zero AXI traffic. Wrap: src=0xFFFFFFFC, cnt=2 -> second araddr=0x00000000.
- Reset asserted while in W with awvalid high -> next cycle all valids=0, busy=0, state IDLE; a following start copies correctly.

Source files
------------

// File: rtl/ytydla_dma_copy_master.sv
// ytydla DMA copy master: copies word_cnt words from src_addr to dst_addr
// over AXI4, one single-beat read then one single-beat write per word,
// with at most one transaction outstanding.
module ytydla_dma_copy_master #(
    parameter int unsigned W_ID   = 4,
    parameter int unsigned ID_VAL = 0,
    parameter int unsigned W_ADR  = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_CNT  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command / status
    input  logic                  start,
    input  logic [W_ADR-1:0]      src_addr,
    input  logic [W_ADR-1:0]      dst_addr,
    input  logic [W_CNT-1:0]      word_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    // read address channel
    output logic [W_ID-1:0]       arid,
    output logic [W_ADR-1:0]      araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    // read data channel
    input  logic [W_ID-1:0]       rid,
    input  logic [W_DATA-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    // write address channel
    output logic [W_ID-1:0]       awid,
    output logic [W_ADR-1:0]      awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    // write data channel
    output logic [W_DATA-1:0]     wdata,
    output logic [W_DATA/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // write response channel
    input  logic [W_ID-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int unsigned BYTES = W_DATA / 8;
    localparam int unsigned SHIFT = $clog2(BYTES);
    localparam logic [W_ID-1:0]  ID         = W_ID'(ID_VAL);
    localparam logic [W_ADR-1:0] ALIGN_MASK = W_ADR'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t            state;
    logic [W_ADR-1:0]  src_q;
    logic [W_ADR-1:0]  dst_q;
    logic [W_CNT-1:0]  cnt_q;
    logic [W_CNT-1:0]  idx;

    logic              misaligned;
    logic              r_bad;
    logic              b_bad;
    logic              aw_ok;
    logic              w_ok;
    logic [W_CNT-1:0]  idx_inc;

    // Byte address of word i relative to base; wraps modulo 2^W_ADR.
    function automatic logic [W_ADR-1:0] word_addr(input logic [W_ADR-1:0] base,
                                                   input logic [W_CNT-1:0] i);
        return base + (W_ADR'(i) << SHIFT);
    endfunction

    // Fixed single-beat, full-width, constant-ID transfer attributes.
    assign arid   = ID;
    assign awid   = ID;
    assign arlen  = 8'd0;
    assign awlen  = 8'd0;
    assign arsize = 3'(SHIFT);
    assign awsize = 3'(SHIFT);
    assign wstrb  = '1;
    assign wlast  = 1'b1;

    // Command checks and response decode.
    assign misaligned = |((src_addr | dst_addr) & ALIGN_MASK);
    assign r_bad      = (rresp != 2'b00) || (rid != ID) || !rlast;
    assign b_bad      = (bresp != 2'b00) || (bid != ID);
    assign aw_ok      = !awvalid || awready;
    assign w_ok       = !wvalid || wready;
    assign idx_inc    = idx + W_CNT'(1);

    // Copy sequencer: state and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            araddr  <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awaddr  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        cnt_q <= word_cnt;
                        idx   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        if (word_cnt == '0) begin
                            state <= S_DONE;
                        end else if (misaligned) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            araddr  <= src_addr;
                            arvalid <= 1'b1;
                            state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        wdata  <= rdata;
                        if (r_bad) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            awaddr  <= word_addr(dst_q, idx);
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= S_W;
                        end
                    end
                end
                S_W: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        bready <= 1'b1;
                        state  <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (b_bad) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx <= idx_inc;
                            if (idx_inc == cnt_q) begin
                                state <= S_DONE;
                            end else begin
                                araddr  <= word_addr(src_q, idx_inc);
                                arvalid <= 1'b1;
                                state   <= S_AR;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
